// File: rtl/mantissa_multiplier_seq_if.sv
// -----------------------------------------------------------------------------
// mantissa_multiplier_seq_if
// Handshake and data bundle between the exponent/operand stage (master) and
// the sequential mantissa multiplier (slave).
//   start/ready : request accepted when both are high
//   in0/in1     : operand fractions (hidden bit not included)
//   zero0/zero1 : operand is a true zero
//   rnd_mode    : 0 = truncate, 1 = round-to-nearest-even
//   out/carry   : normalised rounded fraction, product >= 2 flag
//   done        : one-cycle pulse, out/carry valid
//   inexact     : present only when MANT_MUL_INEXACT_EN is defined
// -----------------------------------------------------------------------------
interface mantissa_multiplier_seq_if #(
   parameter int BIT_WIDTH = 23
);
   logic                 start;
   logic                 ready;
   logic [BIT_WIDTH-1:0] in0;
   logic [BIT_WIDTH-1:0] in1;
   logic                 zero0;
   logic                 zero1;
   logic                 rnd_mode;
   logic [BIT_WIDTH-1:0] out;
   logic                 carry;
   logic                 done;
`ifdef MANT_MUL_INEXACT_EN
   logic                 inexact;
`endif

   modport master (
      output start, in0, in1, zero0, zero1, rnd_mode,
      input  ready, out, carry, done
`ifdef MANT_MUL_INEXACT_EN
      , input inexact
`endif
   );

   modport slave (
      input  start, in0, in1, zero0, zero1, rnd_mode,
      output ready, out, carry, done
`ifdef MANT_MUL_INEXACT_EN
      , output inexact
`endif
   );
endinterface

// File: rtl/mantissa_multiplier_seq.sv
// -----------------------------------------------------------------------------
// mantissa_multiplier_seq
// Sequential significand multiplier: computes 1.in0 x 1.in1 with a shift-add
// engine retiring BITS_PER_CYCLE multiplier bits per clock, then normalises
// and rounds (truncate or RNE) and reports fraction plus carry (product >= 2).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mantissa_multiplier_seq_if.slave (start/ready, operands, zero
//           flags, rnd_mode, out, carry, done)
// Optional feature macro: MANT_MUL_INEXACT_EN adds bus.inexact (g|s before
// rounding, registered with done).
// Latency: start accepted at edge 0, done high after edge N+1 where
// N = ceil((BIT_WIDTH+1)/BITS_PER_CYCLE).
// -----------------------------------------------------------------------------
module mantissa_multiplier_seq #(
   parameter int BIT_WIDTH      = 23,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   mantissa_multiplier_seq_if.slave   bus
);
   localparam int W  = BIT_WIDTH;
   localparam int PW = 2 * W + 2;
   localparam int N  = (W + 1 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   if ((BITS_PER_CYCLE != 1) && (BITS_PER_CYCLE != 2)) begin : g_bpc_illegal
      $error("mantissa_multiplier_seq: BITS_PER_CYCLE must be 1 or 2");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_RND  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W:0]      r_mcand;
   logic [W:0]      r_mplier;
   logic [PW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_zero;
   logic            r_rnd_mode;
   logic [W-1:0]    r_out;
   logic            r_carry;
   logic            r_done;
`ifdef MANT_MUL_INEXACT_EN
   logic            r_inexact;
   logic            w_res_inexact;
`endif

   logic            w_step_one;
   logic [1:0]      w_bits;
   logic [W+2:0]    w_pp;
   logic [W+2:0]    w_hi;
   logic            w_carry_pre;
   logic [W-1:0]    w_frac;
   logic            w_g;
   logic            w_s;
   logic            w_inc;
   logic [W:0]      w_sum;
   logic [W-1:0]    w_res_out;
   logic            w_res_carry;

   // Shift-add step: one bit per cycle, or two except for the odd final step
   always_comb begin
      w_step_one = (BITS_PER_CYCLE == 1) ||
                   ((((W + 1) % 2) == 1) && (r_cnt == CW'(1)));
      if (w_step_one) begin
         w_bits = {1'b0, r_mplier[0]};
      end else begin
         w_bits = r_mplier[1:0];
      end
      w_pp = ({(W+3){w_bits[0]}} & {2'b00, r_mcand}) +
             ({(W+3){w_bits[1]}} & {1'b0, r_mcand, 1'b0});
      // Partial products land on the upper half; the shift right keeps the
      // running product aligned so the final value needs no correction.
      w_hi = {2'b00, r_acc[PW-1:W+1]} + w_pp;
   end

   // Normalise and round the finished product held in the accumulator
   always_comb begin
      w_carry_pre = r_acc[PW-1];
      if (w_carry_pre) begin
         w_frac = r_acc[2*W:W+1];
         w_g    = r_acc[W];
         w_s    = |r_acc[W-1:0];
      end else begin
         w_frac = r_acc[2*W-1:W];
         w_g    = r_acc[W-1];
         w_s    = |r_acc[W-2:0];
      end
      w_inc = r_rnd_mode & w_g & (w_s | w_frac[0]);
      w_sum = {1'b0, w_frac} + {{W{1'b0}}, w_inc};
      if (r_zero) begin
         w_res_out   = {W{1'b0}};
         w_res_carry = 1'b0;
      end else if (w_sum[W]) begin
         // Rounding overflowed an all-ones fraction: result is exactly 2.0
         w_res_out   = {W{1'b0}};
         w_res_carry = 1'b1;
      end else begin
         w_res_out   = w_sum[W-1:0];
         w_res_carry = w_carry_pre;
      end
`ifdef MANT_MUL_INEXACT_EN
      w_res_inexact = (~r_zero) & (w_g | w_s);
`endif
   end

   // FSM next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_MUL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_RND;
            end else begin
               w_state_nxt = S_MUL;
            end
         end
         S_RND:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand latch, shift-add engine and registered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand    <= {(W+1){1'b0}};
         r_mplier   <= {(W+1){1'b0}};
         r_acc      <= {PW{1'b0}};
         r_cnt      <= {CW{1'b0}};
         r_zero     <= 1'b0;
         r_rnd_mode <= 1'b0;
         r_out      <= {W{1'b0}};
         r_carry    <= 1'b0;
         r_done     <= 1'b0;
`ifdef MANT_MUL_INEXACT_EN
         r_inexact  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand    <= {1'b1, bus.in0};
                  r_mplier   <= {1'b1, bus.in1};
                  r_zero     <= bus.zero0 | bus.zero1;
                  r_rnd_mode <= bus.rnd_mode;
                  r_acc      <= {PW{1'b0}};
                  r_cnt      <= CW'(N);
               end
            end
            S_MUL: begin
               if (w_step_one) begin
                  r_acc    <= PW'({w_hi, r_acc[W:0]} >> 2'd1);
                  r_mplier <= r_mplier >> 2'd1;
               end else begin
                  r_acc    <= PW'({w_hi, r_acc[W:0]} >> 2'd2);
                  r_mplier <= r_mplier >> 2'd2;
               end
               r_cnt <= r_cnt - CW'(1);
            end
            S_RND: begin
               r_out     <= w_res_out;
               r_carry   <= w_res_carry;
               r_done    <= 1'b1;
`ifdef MANT_MUL_INEXACT_EN
               r_inexact <= w_res_inexact;
`endif
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready = (r_state == S_IDLE);
   assign bus.out   = r_out;
   assign bus.carry = r_carry;
   assign bus.done  = r_done;
`ifdef MANT_MUL_INEXACT_EN
   assign bus.inexact = r_inexact;
`endif

endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// -----------------------------------------------------------------------------
// tb_mantissa_multiplier_seq
// Directed bench for mantissa_multiplier_seq: dut_a uses BITS_PER_CYCLE=1,
// dut_b uses BITS_PER_CYCLE=2, both BIT_WIDTH=23. Expected results are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mantissa_multiplier_seq;
   localparam int W     = 23;
   localparam int LAT_A = 25;
   localparam int LAT_B = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   mantissa_multiplier_seq_if #(.BIT_WIDTH(W)) ifa ();
   mantissa_multiplier_seq_if #(.BIT_WIDTH(W)) ifb ();

   mantissa_multiplier_seq #(.BIT_WIDTH(W), .BITS_PER_CYCLE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   mantissa_multiplier_seq #(.BIT_WIDTH(W), .BITS_PER_CYCLE(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   logic [W-1:0] t_in0, t_in1;
   logic         t_z0, t_z1, t_rnd, t_start_a, t_start_b, t_sel;

   assign ifa.start = t_start_a;  assign ifb.start = t_start_b;
   assign ifa.in0 = t_in0;        assign ifb.in0 = t_in0;
   assign ifa.in1 = t_in1;        assign ifb.in1 = t_in1;
   assign ifa.zero0 = t_z0;       assign ifb.zero0 = t_z0;
   assign ifa.zero1 = t_z1;       assign ifb.zero1 = t_z1;
   assign ifa.rnd_mode = t_rnd;   assign ifb.rnd_mode = t_rnd;

   logic         o_ready, o_done, o_carry, o_inexact;
   logic [W-1:0] o_out;

   // Observe whichever instance the current test targets
   always_comb begin
      o_ready = t_sel ? ifb.ready : ifa.ready;
      o_done  = t_sel ? ifb.done  : ifa.done;
      o_carry = t_sel ? ifb.carry : ifa.carry;
      o_out   = t_sel ? ifb.out   : ifa.out;
`ifdef MANT_MUL_INEXACT_EN
      o_inexact = t_sel ? ifb.inexact : ifa.inexact;
`else
      o_inexact = 1'b0;
`endif
   end

   typedef struct {
      logic [W-1:0] in0;
      logic [W-1:0] in1;
      logic         z0;
      logic         z1;
      logic         rnd;
      logic [W-1:0] eout;
      logic         ecarry;
      logic         einex;
   } vec_t;

   localparam int NV = 11;
   vec_t vt [NV];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic s, input vec_t v);
      @(negedge clk);
      t_sel = s;
      t_in0 = v.in0; t_in1 = v.in1; t_z0 = v.z0; t_z1 = v.z1; t_rnd = v.rnd;
      if (s) t_start_b = 1'b1; else t_start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_start_a = 1'b0; t_start_b = 1'b0;
      // operands are free to change once accepted
      t_in0 = W'($urandom); t_in1 = W'($urandom);
      t_z0 = 1'b0; t_z1 = 1'b0; t_rnd = ~v.rnd;
   endtask

   // n = number of edges after the accepting edge until done is seen
   task automatic wait_done(output int n);
      n = 0;
      while ((o_done !== 1'b1) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic chk_result(input string tag, input vec_t v);
      chk({tag, "_out"}, 32'(o_out), 32'(v.eout));
      chk({tag, "_carry"}, 32'(o_carry), 32'(v.ecarry));
`ifdef MANT_MUL_INEXACT_EN
      chk({tag, "_inexact"}, 32'(o_inexact), 32'(v.einex));
`endif
   endtask

   task automatic run_op(input logic s, input int lat, input vec_t v, input string tag);
      int n;
      start_op(s, v);
      chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
      wait_done(n);
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk_result(tag, v);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
      chk({tag, "_ready_back"}, 32'(o_ready), 32'd1);
      chk({tag, "_out_hold"}, 32'(o_out), 32'(v.eout));
   endtask

   initial begin
      int n, nd, first_c;
      vt[0]  = '{23'h000000, 23'h000000, 1'b0, 1'b0, 1'b1, 23'h000000, 1'b0, 1'b0};
      vt[1]  = '{23'h400000, 23'h400000, 1'b0, 1'b0, 1'b1, 23'h100000, 1'b1, 1'b0};
      vt[2]  = '{23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b1, 23'h7FFFFE, 1'b1, 1'b1};
      vt[3]  = '{23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 23'h7FFFFE, 1'b1, 1'b1};
      vt[4]  = '{23'h000001, 23'h400000, 1'b0, 1'b0, 1'b0, 23'h400001, 1'b0, 1'b1};
      vt[5]  = '{23'h000001, 23'h400000, 1'b0, 1'b0, 1'b1, 23'h400002, 1'b0, 1'b1};
      // tie with even lsb: no increment
      vt[6]  = '{23'h000003, 23'h400000, 1'b0, 1'b0, 1'b1, 23'h400004, 1'b0, 1'b1};
      // product = 2 - 2^-24 exactly: RNE rounds up to 2.0, truncate keeps all ones
      vt[7]  = '{23'h042108, 23'h780000, 1'b0, 1'b0, 1'b1, 23'h000000, 1'b1, 1'b1};
      vt[8]  = '{23'h042108, 23'h780000, 1'b0, 1'b0, 1'b0, 23'h7FFFFF, 1'b0, 1'b1};
      vt[9]  = '{23'h123456, 23'h654321, 1'b0, 1'b1, 1'b1, 23'h000000, 1'b0, 1'b0};
      vt[10] = '{23'h7FFFFF, 23'h7FFFFF, 1'b1, 1'b0, 1'b1, 23'h000000, 1'b0, 1'b0};

      t_in0 = '0; t_in1 = '0; t_z0 = 1'b0; t_z1 = 1'b0; t_rnd = 1'b0;
      t_start_a = 1'b0; t_start_b = 1'b0; t_sel = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         t_sel = s[0];
         #1;
         chk("rst_ready", 32'(o_ready), 32'd1);
         chk("rst_done", 32'(o_done), 32'd0);
         chk("rst_out", 32'(o_out), 32'd0);
         chk("rst_carry", 32'(o_carry), 32'd0);
         chk("rst_inexact", 32'(o_inexact), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < NV; i++) begin
            run_op(s[0], (s == 0) ? LAT_A : LAT_B, vt[i], $sformatf("v%0d_b%0d", i, s + 1));
         end
      end

      // Back-to-back on the two-bit engine: start accepted while done is high
      start_op(1'b1, vt[1]);
      wait_done(n);
      chk("b2b_first_out", 32'(o_out), 32'(vt[1].eout));
      t_in0 = vt[5].in0; t_in1 = vt[5].in1; t_rnd = vt[5].rnd;
      t_start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_start_b = 1'b0;
      chk("b2b_accepted", 32'(o_ready), 32'd0);
      wait_done(n);
      chk("b2b_latency", 32'(n), 32'(LAT_B));
      chk_result("b2b_second", vt[5]);

      // Start pulses during an operation are ignored
      start_op(1'b0, vt[9]);
      nd = 0; first_c = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 5) begin
            t_in0 = vt[1].in0; t_in1 = vt[1].in1; t_z1 = 1'b0; t_rnd = 1'b1;
            t_start_a = 1'b1;
         end
         if (c == 7) t_start_a = 1'b0;
         if (o_done === 1'b1) begin
            nd++;
            if (nd == 1) begin
               first_c = c;
               chk_result("ign_start", vt[9]);
            end
         end
      end
      chk("ign_done_count", 32'(nd), 32'd1);
      chk("ign_latency", 32'(first_c), 32'(LAT_A));

      // Reset in the middle of an operation
      run_op(1'b0, LAT_A, vt[1], "pre_rst");
      start_op(1'b0, vt[2]);
      repeat (10) @(negedge clk);
      chk("mid_out_held", 32'(o_out), 32'(vt[1].eout));
      chk("mid_busy", 32'(o_ready), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 32'(o_out), 32'd0);
      chk("mid_rst_carry", 32'(o_carry), 32'd0);
      chk("mid_rst_ready", 32'(o_ready), 32'd1);
      chk("mid_rst_done", 32'(o_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_done === 1'b1) nd++;
      end
      chk("mid_rst_no_done", 32'(nd), 32'd0);
      run_op(1'b1, LAT_B, vt[1], "post_rst_b2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
